// File: rtl/row_cache_pkg.sv
// Shared types for the row cache controller: per-slot tag record, FSM states, slot-count helper.
// Slot fields are sized for the widest supported build (CHWIDTH <= 8, ADDRWIDTH <= 32); narrower builds zero-extend.
package row_cache_pkg;

  localparam int CH_W_MAX  = 8;
  localparam int ROW_W_MAX = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [CH_W_MAX-1:0]  age;
    logic [ROW_W_MAX-1:0] rowaddr;
  } slot_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_FILL,
    S_DONE
  } state_t;

  function automatic int nslots(input int chwidth);
    return 1 << chwidth;
  endfunction

endpackage

// File: rtl/row_cache_victim_sel.sv
// Combinational tag match and replacement choice over the whole slot array.
// Hit picks the lowest matching index; victim is the lowest free slot, else the oldest (lowest index on a tie).
module row_cache_victim_sel
  import row_cache_pkg::*;
#(
  parameter  int CHWIDTH = 5,
  localparam int NSLOTS  = nslots(CHWIDTH)
) (
  input  slot_t                slots_i [NSLOTS],
  input  logic [ROW_W_MAX-1:0] row_i,
  output logic                 hit_o,
  output logic [CHWIDTH-1:0]   hit_slot_o,
  output logic [CHWIDTH-1:0]   victim_slot_o,
  output logic                 victim_dirty_o
);

  logic                free_found;
  logic [CHWIDTH-1:0]  free_slot;
  logic [CHWIDTH-1:0]  lru_slot;
  logic [CH_W_MAX-1:0] lru_age;
  logic [CHWIDTH-1:0]  victim;

  always_comb begin
    hit_o      = 1'b0;
    hit_slot_o = '0;
    free_found = 1'b0;
    free_slot  = '0;
    // Descending scans so the lowest qualifying index is the last one written.
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (slots_i[i].valid && (slots_i[i].rowaddr == row_i)) begin
        hit_o      = 1'b1;
        hit_slot_o = CHWIDTH'(i);
      end
      if (!slots_i[i].valid) begin
        free_found = 1'b1;
        free_slot  = CHWIDTH'(i);
      end
    end

    lru_slot = '0;
    lru_age  = slots_i[0].age;
    for (int i = 1; i < NSLOTS; i++) begin
      if (slots_i[i].age > lru_age) begin
        lru_slot = CHWIDTH'(i);
        lru_age  = slots_i[i].age;
      end
    end

    victim         = free_found ? free_slot : lru_slot;
    victim_slot_o  = victim;
    victim_dirty_o = slots_i[victim].valid & slots_i[victim].dirty;
  end

endmodule

// File: rtl/row_cache_ctrl.sv
// Fully associative row-tag manager with true-LRU replacement and evict/fill handshakes.
// Optional ROW_CACHE_STATS_EN adds saturating hit/miss/evict counters.
module row_cache_ctrl
  import row_cache_pkg::*;
#(
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [ADDRWIDTH-1:0] row_id,
  output logic                 ready,
  output logic                 done,
  output logic                 hit,
  output logic [CHWIDTH-1:0]   crow_id,
  output logic                 hold,
  output logic                 evict_req,
  output logic [CHWIDTH-1:0]   evict_slot,
  output logic [ADDRWIDTH-1:0] evict_row,
  output logic                 fill_req,
  output logic [CHWIDTH-1:0]   fill_slot,
  output logic [ADDRWIDTH-1:0] fill_row,
  input  logic                 sync
`ifdef ROW_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          evict_cnt
`endif
);

  localparam int                  NSLOTS     = nslots(CHWIDTH);
  localparam logic [CH_W_MAX-1:0] AGE_OLDEST = CH_W_MAX'(NSLOTS - 1);

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   row_q, row_d;
  logic                   wr_q, wr_d;
  logic [CHWIDTH-1:0]     slot_q, slot_d;
  logic                   hit_q, hit_d;
  slot_t                  slots_q [NSLOTS];

  logic [ROW_W_MAX-1:0]   row_ext;
  logic                   vs_hit;
  logic [CHWIDTH-1:0]     vs_hit_slot;
  logic [CHWIDTH-1:0]     vs_victim_slot;
  logic                   vs_victim_dirty;

  assign row_ext = ROW_W_MAX'(row_q);

  row_cache_victim_sel #(.CHWIDTH(CHWIDTH)) u_victim_sel (
    .slots_i        (slots_q),
    .row_i          (row_ext),
    .hit_o          (vs_hit),
    .hit_slot_o     (vs_hit_slot),
    .victim_slot_o  (vs_victim_slot),
    .victim_dirty_o (vs_victim_dirty)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wr_d    = wr_q;
    slot_d  = slot_q;
    hit_d   = hit_q;
    case (state_q)
      S_IDLE: begin
        if (rd || wr) begin
          state_d = S_LOOKUP;
          row_d   = row_id;
          wr_d    = wr;
        end
      end
      S_LOOKUP: begin
        slot_d = vs_hit ? vs_hit_slot : vs_victim_slot;
        hit_d  = vs_hit;
        if (vs_hit)               state_d = S_DONE;
        else if (vs_victim_dirty) state_d = S_EVICT;
        else                      state_d = S_FILL;
      end
      S_EVICT: if (sync) state_d = S_FILL;
      S_FILL:  if (sync) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      wr_q    <= 1'b0;
      slot_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wr_q    <= wr_d;
      slot_q  <= slot_d;
      hit_q   <= hit_d;
    end
  end

  // A filled slot starts as oldest so the DONE update ages every other valid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOTS; i++) begin
        slots_q[i].valid   <= 1'b0;
        slots_q[i].dirty   <= 1'b0;
        slots_q[i].age     <= AGE_OLDEST;
        slots_q[i].rowaddr <= '0;
      end
    end else begin
      case (state_q)
        S_EVICT: begin
          if (sync) begin
            slots_q[slot_q].valid <= 1'b0;
            slots_q[slot_q].dirty <= 1'b0;
          end
        end
        S_FILL: begin
          if (sync) begin
            slots_q[slot_q].valid   <= 1'b1;
            slots_q[slot_q].dirty   <= 1'b0;
            slots_q[slot_q].rowaddr <= row_ext;
            slots_q[slot_q].age     <= AGE_OLDEST;
          end
        end
        S_DONE: begin
          for (int i = 0; i < NSLOTS; i++) begin
            if ((CHWIDTH'(i) != slot_q) && slots_q[i].valid &&
                (slots_q[i].age < slots_q[slot_q].age))
              slots_q[i].age <= slots_q[i].age + CH_W_MAX'(1);
          end
          slots_q[slot_q].age <= '0;
          if (wr_q) slots_q[slot_q].dirty <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign hit        = done & hit_q;
  assign crow_id    = done ? slot_q : '0;
  assign evict_req  = (state_q == S_EVICT);
  assign fill_req   = (state_q == S_FILL);
  assign hold       = evict_req | fill_req;
  assign evict_slot = evict_req ? slot_q : '0;
  assign evict_row  = evict_req ? slots_q[slot_q].rowaddr[ADDRWIDTH-1:0] : '0;
  assign fill_slot  = fill_req ? slot_q : '0;
  assign fill_row   = fill_req ? row_q : '0;

`ifdef ROW_CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      evict_cnt <= '0;
    end else begin
      if (done && hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
      if (done && !hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
      if (evict_req && sync && (evict_cnt != '1)) evict_cnt <= evict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_row_cache_ctrl.sv
// Scoreboard bench for row_cache_ctrl (CHWIDTH=2, ADDRWIDTH=8) against a recency-list cache model.
module tb_row_cache_ctrl;

  localparam int CHW = 2;
  localparam int AW  = 8;
  localparam int NS  = 4;

  logic           clk, rst, rd, wr, sync;
  logic [AW-1:0]  row_id;
  logic           ready, done, hit, hold, evict_req, fill_req;
  logic [CHW-1:0] crow_id, evict_slot, fill_slot;
  logic [AW-1:0]  evict_row, fill_row;
`ifdef ROW_CACHE_STATS_EN
  logic [31:0]    hit_cnt, miss_cnt, evict_cnt;
`endif

  row_cache_ctrl #(.CHWIDTH(CHW), .ADDRWIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd         (rd),
    .wr         (wr),
    .row_id     (row_id),
    .ready      (ready),
    .done       (done),
    .hit        (hit),
    .crow_id    (crow_id),
    .hold       (hold),
    .evict_req  (evict_req),
    .evict_slot (evict_slot),
    .evict_row  (evict_row),
    .fill_req   (fill_req),
    .fill_slot  (fill_slot),
    .fill_row   (fill_row),
    .sync       (sync)
`ifdef ROW_CACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .evict_cnt  (evict_cnt)
`endif
  );

  typedef struct {bit hit; int slot; int cyc;} done_exp_t;
  typedef struct {int slot; int row;} xfer_t;

  int        checks = 0;
  int        errors = 0;
  int        cyc    = 0;
  done_exp_t done_q[$];
  xfer_t     evict_q[$];
  xfer_t     fill_q[$];

  // Reference model: slot contents plus a recency list (front = most recent).
  bit        m_valid [NS];
  bit        m_dirty [NS];
  int        m_row   [NS];
  int        lru[$];

  bit        sync_en = 1'b1;
  int        wcnt    = 0;
  bit        ev_prev = 1'b0;
  bit        fl_prev = 1'b0;
  xfer_t     ev_cur, fl_cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_row[i]   = 0;
    end
    lru.delete();
  endfunction

  task automatic model_access(input bit is_wr, input int row, input int issue_cyc);
    int        slot;
    bit        h;
    done_exp_t d;
    xfer_t     x;
    slot = -1;
    h    = 1'b0;
    for (int i = 0; i < NS; i++)
      if (slot < 0 && m_valid[i] && m_row[i] == row) begin
        slot = i;
        h    = 1'b1;
      end
    if (!h) begin
      for (int i = 0; i < NS; i++)
        if (slot < 0 && !m_valid[i]) slot = i;
      if (slot < 0) slot = lru[lru.size()-1];
      if (m_valid[slot] && m_dirty[slot]) begin
        x.slot = slot;
        x.row  = m_row[slot];
        evict_q.push_back(x);
      end
      x.slot = slot;
      x.row  = row;
      fill_q.push_back(x);
      m_valid[slot] = 1'b1;
      m_row[slot]   = row;
      m_dirty[slot] = 1'b0;
    end
    for (int i = 0; i < lru.size(); i++)
      if (lru[i] == slot) begin
        lru.delete(i);
        break;
      end
    lru.push_front(slot);
    if (is_wr) m_dirty[slot] = 1'b1;
    d.hit  = h;
    d.slot = slot;
    d.cyc  = issue_cyc;
    done_q.push_back(d);
  endtask

  task automatic flush_and_reset_model();
    done_q.delete();
    evict_q.delete();
    fill_q.delete();
    model_reset();
  endtask

  // Requests raised while not ready are junk the DUT must ignore.
  task automatic do_req(input bit r, input bit w, input int row);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready) begin
      if (n >= 200) begin
        rd = 1'b0;
        wr = 1'b0;
        chk("ready_timeout", 0, 1);
        return;
      end
      rd     = ($urandom_range(0, 3) == 0);
      wr     = ($urandom_range(0, 3) == 0);
      row_id = AW'($urandom);
      n++;
      @(negedge clk);
    end
    rd     = r;
    wr     = w;
    row_id = AW'(row);
    model_access(w, row, cyc);
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(ready && done_q.size() == 0)) begin
      if (n >= 500) begin
        chk("drain_timeout", 0, 1);
        return;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush_and_reset_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Backing store: random 0..3 cycle sync latency, spurious strobes outside evict/fill.
  initial begin
    sync = 1'b0;
    forever begin
      @(negedge clk);
      if (!sync_en) sync = 1'b0;
      else if (hold) begin
        if (wcnt == 0) begin
          sync = 1'b1;
          wcnt = $urandom_range(0, 3);
        end else begin
          sync = 1'b0;
          wcnt--;
        end
      end else sync = ($urandom_range(0, 5) == 0);
    end
  end

  initial begin
    done_exp_t d;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (done) begin
          if (done_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            d = done_q.pop_front();
            chk("done_hit", int'(hit), int'(d.hit));
            chk("done_crow_id", int'(crow_id), d.slot);
            if (d.hit) chk("hit_latency", cyc - d.cyc, 2);
          end
        end
        if (evict_req && !ev_prev) begin
          if (evict_q.size() == 0) chk("unexpected_evict", 1, 0);
          else begin
            ev_cur = evict_q.pop_front();
            chk("evict_slot", int'(evict_slot), ev_cur.slot);
            chk("evict_row", int'(evict_row), ev_cur.row);
            chk("evict_hold", int'(hold), 1);
          end
        end else if (evict_req) begin
          chk("evict_slot_stable", int'(evict_slot), ev_cur.slot);
          chk("evict_row_stable", int'(evict_row), ev_cur.row);
        end
        if (fill_req && !fl_prev) begin
          if (fill_q.size() == 0) chk("unexpected_fill", 1, 0);
          else begin
            fl_cur = fill_q.pop_front();
            chk("fill_slot", int'(fill_slot), fl_cur.slot);
            chk("fill_row", int'(fill_row), fl_cur.row);
            chk("fill_hold", int'(hold), 1);
          end
        end else if (fill_req) begin
          chk("fill_slot_stable", int'(fill_slot), fl_cur.slot);
          chk("fill_row_stable", int'(fill_row), fl_cur.row);
        end
      end
      ev_prev = evict_req;
      fl_prev = fill_req;
    end
  end

  initial begin
    int n;
    int op;
    rst    = 1'b1;
    rd     = 1'b0;
    wr     = 1'b0;
    row_id = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_crow_id", int'(crow_id), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_evict_req", int'(evict_req), 0);
    chk("rst_fill_req", int'(fill_req), 0);
    chk("rst_slots_rows", int'(evict_slot) + int'(evict_row) + int'(fill_slot) + int'(fill_row), 0);
    rst = 1'b0;

    // Cold read, then write/read hit on the same row.
    do_req(1, 0, 'h10);
    wait_drain();
    do_req(0, 1, 'h10);
    do_req(1, 0, 'h10);
    wait_drain();

    // Fill all slots by write, then a fifth row evicts the oldest dirty slot.
    do_reset();
    for (int r = 1; r <= 4; r++) do_req(0, 1, r);
    do_req(0, 1, 'h05);
    wait_drain();

    // Touching row 1 makes row 2 (slot 1) the LRU victim.
    do_reset();
    for (int r = 1; r <= 4; r++) do_req(0, 1, r);
    do_req(1, 0, 'h01);
    do_req(1, 0, 'h06);
    wait_drain();

    // rd and wr together behave as a write: the slot later evicts.
    do_reset();
    do_req(1, 1, 'h20);
    for (int r = 'h21; r <= 'h24; r++) do_req(1, 0, r);
    wait_drain();

    // Reset while FILL is waiting on sync.
    do_reset();
    sync_en = 1'b0;
    do_req(1, 0, 'h30);
    n = 0;
    while (!fill_req && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("reached_fill", int'(fill_req), 1);
    rst = 1'b1;
    flush_and_reset_model();
    @(posedge clk);
    #1;
    chk("abort_ready", int'(ready), 1);
    chk("abort_fill_req", int'(fill_req), 0);
    chk("abort_hold", int'(hold), 0);
    chk("abort_evict_req", int'(evict_req), 0);
    @(negedge clk);
    rst     = 1'b0;
    sync_en = 1'b1;
    do_req(1, 0, 'h30);
    wait_drain();

    // Random traffic over a small row pool so hits, misses and evictions mix.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, $urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", done_q.size() + evict_q.size() + fill_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
